// File: rtl/dot_channel_sched_if.sv
// dot_channel_sched_if
//   Bundles every non-clock, non-reset signal of dot_channel_sched.
//   master : the scheduler side (drives dc_load/dc_cs, the result port and status).
//   slave  : the environment side (layer controller, dot_channel datapath, result consumer).
// Signals:
//   start, abort           layer-controller requests
//   dc_load, dc_cs         to dot_channel load / weight-bank select
//   dc_valid, dc_q         from dot_channel valid / dot product
//   out_valid, out_ready,
//   out_data, out_idx      result stream (valid/ready) with bank index
//   busy, done, err        status
interface dot_channel_sched_if #(
  parameter int DATA_LEN = 25
);
  logic                start;
  logic                abort;
  logic                dc_load;
  logic [3:0]          dc_cs;
  logic                dc_valid;
  logic [DATA_LEN-1:0] dc_q;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic [3:0]          out_idx;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, abort, dc_valid, dc_q, out_ready,
    output dc_load, dc_cs, out_valid, out_data, out_idx, busy, done, err
  );

  modport slave (
    output start, abort, dc_valid, dc_q, out_ready,
    input  dc_load, dc_cs, out_valid, out_data, out_idx, busy, done, err
  );
endinterface

// File: rtl/dot_channel_sched.sv
// dot_channel_sched
//   Sequences one dot_channel instance over weight banks 0..NUM_CS-1: raises
//   load per bank, waits for valid, captures the dot product and presents it
//   on a valid/ready result port tagged with the bank index.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus_io  dot_channel_sched_if.master (start/abort, dc_* channel controls,
//           out_* result stream, busy/done/err status)
// Optional feature:
//   DOT_SCHED_TIMEOUT_EN - when defined, a LOAD that sees no dc_valid for
//   TIMEOUT cycles sets the sticky err flag and returns to IDLE. When not
//   defined, LOAD waits forever and err is constant 0.
module dot_channel_sched #(
  parameter int NUM_CS   = 12,
  parameter int GAP      = 0,
  parameter int TIMEOUT  = 63,
  parameter int DATA_LEN = 25
) (
  input  logic                clk,
  input  logic                rst,
  dot_channel_sched_if.master bus_io
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT, S_GAP} state_t;

  localparam logic [3:0] LAST_CS  = 4'(NUM_CS - 1);
  // GAP state counts down from GAP-1 so it lasts exactly GAP cycles.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t              state_q, state_d;
  logic                dc_load_q, dc_load_d;
  logic [3:0]          dc_cs_q, dc_cs_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic [3:0]          out_idx_q, out_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;

`ifdef DOT_SCHED_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    dc_cs_d    = dc_cs_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
`ifdef DOT_SCHED_TIMEOUT_EN
    err_d      = err_q;
    // Held at zero outside LOAD, so every LOAD entry starts counting from 0.
    to_cnt_d   = '0;
`endif
    if (bus_io.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.start) begin
            state_d = S_LOAD;
            dc_cs_d = 4'd0;
`ifdef DOT_SCHED_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (bus_io.dc_valid) begin
            out_data_d = bus_io.dc_q;
            out_idx_d  = dc_cs_q;
            state_d    = S_OUT;
          end
`ifdef DOT_SCHED_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
        S_OUT: begin
          if (bus_io.out_ready) begin
            if (dc_cs_q == LAST_CS) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              dc_cs_d = dc_cs_q + 4'd1;
              if (GAP > 0) begin
                state_d   = S_GAP;
                gap_cnt_d = GAP_LAST;
              end else begin
                state_d = S_LOAD;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_d = S_LOAD;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Outputs are registered copies of the next-state decode, so they change
    // on the same edge as the state.
    dc_load_d   = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dc_load_q   <= 1'b0;
      dc_cs_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      dc_load_q   <= dc_load_d;
      dc_cs_q     <= dc_cs_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef DOT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign bus_io.err = err_q;
`else
  assign bus_io.err = 1'b0;
`endif

  assign bus_io.dc_load   = dc_load_q;
  assign bus_io.dc_cs     = dc_cs_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_idx   = out_idx_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;

endmodule

// File: tb/tb_dot_channel_sched.sv
// Bench for dot_channel_sched: two instances (NUM_CS=3/GAP=0 and
// NUM_CS=4/GAP=2, TIMEOUT=8) share start/abort/rst; each has its own
// dot_channel stand-in and result consumer. A transaction-level reference
// predicts every output each cycle; directed phases pin literal values.
module tb_dot_channel_sched;
  localparam int DW = 16;
  localparam int TO = 8;
`ifdef DOT_SCHED_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LOAD = 1, M_OUT = 2, M_GAP = 3;

  logic clk, rst, start_s, abort_s;
  logic [1:0] dcv, ordy;
  logic [DW-1:0] dq [2];
  logic [1:0] dc_load_s, out_valid_s, busy_s, done_s, err_s;
  logic [3:0] dc_cs_s [2];
  logic [3:0] out_idx_s [2];
  logic [DW-1:0] out_data_s [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dot_channel_sched_if #(.DATA_LEN(DW)) bus ();
    assign bus.start     = start_s;
    assign bus.abort     = abort_s;
    assign bus.dc_valid  = dcv[gi];
    assign bus.dc_q      = dq[gi];
    assign bus.out_ready = ordy[gi];
    assign dc_load_s[gi]   = bus.dc_load;
    assign dc_cs_s[gi]     = bus.dc_cs;
    assign out_valid_s[gi] = bus.out_valid;
    assign out_data_s[gi]  = bus.out_data;
    assign out_idx_s[gi]   = bus.out_idx;
    assign busy_s[gi]      = bus.busy;
    assign done_s[gi]      = bus.done;
    assign err_s[gi]       = bus.err;
    dot_channel_sched #(
      .NUM_CS((gi == 0) ? 3 : 4), .GAP((gi == 0) ? 0 : 2),
      .TIMEOUT(TO), .DATA_LEN(DW)
    ) u_dut (.clk(clk), .rst(rst), .bus_io(bus));
  end

  function automatic int ncs_of(int i); return (i == 0) ? 3 : 4; endfunction
  function automatic int gap_of(int i); return (i == 0) ? 0 : 2; endfunction

  int errors = 0, checks = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference state per instance
  int mode[2], bank[2], gap_left[2], waitc[2], hidx[2];
  logic [DW-1:0] hdata[2];
  bit done_e[2], err_e[2];
  bit p1_on = 0;
  int log0[$], log1[$], runs0[$], runs1[$];
  int low_run[2], done_cnt[2];
  bit seen_hi[2];
  int idx1_cycles = 0;

  task automatic model_step(int i);
    done_e[i] = 1'b0;
    if (rst) begin
      mode[i] = M_IDLE; bank[i] = 0; err_e[i] = 1'b0; hdata[i] = '0; hidx[i] = 0;
      return;
    end
    if (abort_s) begin mode[i] = M_IDLE; return; end
    case (mode[i])
      M_IDLE: if (start_s) begin bank[i] = 0; err_e[i] = 1'b0; mode[i] = M_LOAD; waitc[i] = 0; end
      M_LOAD: begin
        if (dcv[i]) begin hdata[i] = dq[i]; hidx[i] = bank[i]; mode[i] = M_OUT; end
        else if (TO_ON) begin
          waitc[i]++;
          if (waitc[i] == TO) begin err_e[i] = 1'b1; mode[i] = M_IDLE; end
        end
      end
      M_OUT: if (ordy[i]) begin
        $display("tx inst=%0d bank=%0d data=0x%0h t=%0t", i, hidx[i], hdata[i], $time);
        if (p1_on) begin
          if (i == 0) log0.push_back((hidx[i] << 16) | int'(hdata[i]));
          else        log1.push_back((hidx[i] << 16) | int'(hdata[i]));
        end
        if (bank[i] == ncs_of(i) - 1) begin done_e[i] = 1'b1; mode[i] = M_IDLE; end
        else begin
          bank[i]++;
          if (gap_of(i) > 0) begin mode[i] = M_GAP; gap_left[i] = gap_of(i); end
          else begin mode[i] = M_LOAD; waitc[i] = 0; end
        end
      end
      default: begin
        gap_left[i]--;
        if (gap_left[i] == 0) begin mode[i] = M_LOAD; waitc[i] = 0; end
      end
    endcase
  endtask

  // Single compare process: advance reference at each edge, check #1 later.
  initial begin
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; bank[i] = 0; done_cnt[i] = 0; err_e[i] = 0; done_e[i] = 0;
      hdata[i] = '0; hidx[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d.dc_load", i), dc_load_s[i], mode[i] == M_LOAD);
        chk($sformatf("i%0d.dc_cs", i), dc_cs_s[i], bank[i]);
        chk($sformatf("i%0d.out_valid", i), out_valid_s[i], mode[i] == M_OUT);
        chk($sformatf("i%0d.busy", i), busy_s[i], mode[i] != M_IDLE);
        chk($sformatf("i%0d.done", i), done_s[i], done_e[i]);
        chk($sformatf("i%0d.err", i), err_s[i], err_e[i]);
        if (mode[i] == M_OUT) begin
          chk($sformatf("i%0d.out_data", i), out_data_s[i], hdata[i]);
          chk($sformatf("i%0d.out_idx", i), out_idx_s[i], hidx[i]);
        end
        if (done_s[i]) done_cnt[i]++;
        if (p1_on) begin
          if (dc_load_s[i]) begin
            if (seen_hi[i] && low_run[i] > 0) begin
              if (i == 0) runs0.push_back(low_run[i]); else runs1.push_back(low_run[i]);
            end
            low_run[i] = 0; seen_hi[i] = 1'b1;
          end else if (seen_hi[i]) low_run[i]++;
          if (i == 1 && out_valid_s[1] && out_idx_s[1] == 4'd1) idx1_cycles++;
        end
      end
    end
  end

  // dot_channel stand-in: valid after a latency once load is high.
  bit noise = 0, mute = 0;
  int base_lat = 12;
  int ld_cnt[2], lat[2];
  initial begin
    dcv = '0; dq[0] = '0; dq[1] = '0; ld_cnt[0] = 0; ld_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dc_load_s[i]) begin
          if (ld_cnt[i] == 0) lat[i] = noise ? int'($urandom_range(1, 6)) : base_lat;
          ld_cnt[i]++;
          dcv[i] = !mute && (ld_cnt[i] >= lat[i]);
        end else begin
          ld_cnt[i] = 0;
          dcv[i] = noise && ($urandom_range(0, 3) == 0);
        end
        dq[i] = noise ? DW'($urandom) : DW'(dc_cs_s[i]) + DW'(5);
      end
    end
  end

  // Result consumer: directed (inst0 always ready, inst1 stalls bank 1 for 4 cycles) or random.
  bit rdy_rand = 0;
  int hold = 0;
  initial begin
    ordy = '0;
    forever begin
      @(negedge clk);
      if (rdy_rand) begin
        ordy[0] = ($urandom_range(0, 9) < 6);
        ordy[1] = ($urandom_range(0, 9) < 6);
      end else begin
        ordy[0] = 1'b1;
        if (out_valid_s[1] && out_idx_s[1] == 4'd1 && hold < 4) begin
          ordy[1] = 1'b0; hold++;
        end else ordy[1] = 1'b1;
      end
    end
  end

  initial begin
    int n, snap;
    rst = 1'b1; start_s = 1'b0; abort_s = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst.i%0d.dc_load", i), dc_load_s[i], 0);
      chk($sformatf("rst.i%0d.dc_cs", i), dc_cs_s[i], 0);
      chk($sformatf("rst.i%0d.out_valid", i), out_valid_s[i], 0);
      chk($sformatf("rst.i%0d.out_data", i), out_data_s[i], 0);
      chk($sformatf("rst.i%0d.busy", i), busy_s[i], 0);
      chk($sformatf("rst.i%0d.done", i), done_s[i], 0);
    end
    rst = 1'b0;

    // Phase 1: full passes, start pulse mid-pass ignored.
    hold = 0; p1_on = 1'b1; seen_hi[0] = 0; seen_hi[1] = 0; low_run[0] = 0; low_run[1] = 0;
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    repeat (18) @(negedge clk);
    chk("p1.busy_before_pulse", busy_s, 2'b11);
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && n < 400) begin @(negedge clk); n++; end
    chk("p1.completed", (done_cnt[0] >= 1 && done_cnt[1] >= 1), 1);
    repeat (3) @(negedge clk);
    p1_on = 1'b0;
    chk("p1.done_pulses0", done_cnt[0], 1);
    chk("p1.done_pulses1", done_cnt[1], 1);
    chk("p1.log0.n", log0.size(), 3);
    for (int k = 0; k < log0.size() && k < 3; k++) chk("p1.log0", log0[k], (k << 16) | (k + 5));
    chk("p1.log1.n", log1.size(), 4);
    for (int k = 0; k < log1.size() && k < 4; k++) chk("p1.log1", log1[k], (k << 16) | (k + 5));
    chk("p1.runs0.n", runs0.size(), 2);
    for (int k = 0; k < runs0.size() && k < 2; k++) chk("p1.load_low0", runs0[k], 1);
    chk("p1.runs1.n", runs1.size(), 3);
    if (runs1.size() == 3) begin
      chk("p1.load_low1.b0", runs1[0], 3);
      chk("p1.load_low1.b1", runs1[1], 7);
      chk("p1.load_low1.b2", runs1[2], 3);
    end
    chk("p1.stall_hold_cycles", idx1_cycles, 5);

    // Phase 2: abort together with start while a result is pending.
    base_lat = 3;
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!out_valid_s[0] && n < 50) begin @(negedge clk); n++; end
    chk("p2.reach_out", out_valid_s[0], 1);
    snap = done_cnt[0];
    abort_s = 1'b1; start_s = 1'b1;
    @(posedge clk); #1;
    chk("p2.out_valid", out_valid_s[0], 0);
    chk("p2.busy", busy_s[0], 0);
    chk("p2.dc_load", dc_load_s[0], 0);
    @(negedge clk); abort_s = 1'b0; start_s = 1'b0;
    repeat (5) @(negedge clk);
    chk("p2.no_done", done_cnt[0], snap);
    chk("p2.still_idle", busy_s, 2'b00);

    // Phase 3: asynchronous reset in LOAD of bank 1.
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!(dc_cs_s[0] == 4'd1 && dc_load_s[0]) && n < 60) begin @(negedge clk); n++; end
    chk("p3.reach_bank1", dc_cs_s[0], 1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("p3.i%0d.dc_load", i), dc_load_s[i], 0);
      chk($sformatf("p3.i%0d.dc_cs", i), dc_cs_s[i], 0);
      chk($sformatf("p3.i%0d.out_valid", i), out_valid_s[i], 0);
      chk($sformatf("p3.i%0d.busy", i), busy_s[i], 0);
      chk($sformatf("p3.i%0d.done", i), done_s[i], 0);
    end
    @(negedge clk); rst = 1'b0;
    start_s = 1'b1;
    @(posedge clk); #2;
    chk("p3.restart_cs", dc_cs_s[0], 0);
    chk("p3.restart_load", dc_load_s[0], 1);
    chk("p3.restart_busy", busy_s[0], 1);
    @(negedge clk); start_s = 1'b0;

    // Phase 4: randomized traffic against the reference.
    noise = 1'b1; rdy_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      start_s = ($urandom_range(0, 5) == 0);
      abort_s = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    start_s = 1'b0; rst = 1'b0; abort_s = 1'b1;
    @(negedge clk); abort_s = 1'b0; noise = 1'b0; rdy_rand = 1'b0;
    repeat (2) @(negedge clk);

`ifdef DOT_SCHED_TIMEOUT_EN
    // Phase 5: channel never answers.
    begin
      int hi = 0;
      mute = 1'b1;
      start_s = 1'b1; @(negedge clk); start_s = 1'b0;
      n = 0;
      while (busy_s[0] && n < 60) begin
        if (dc_load_s[0]) hi++;
        @(negedge clk); n++;
      end
      chk("p5.load_cycles", hi, TO);
      chk("p5.err", err_s, 2'b11);
      chk("p5.dc_load", dc_load_s, 2'b00);
      repeat (2) @(negedge clk);
      mute = 1'b0;
      start_s = 1'b1;
      @(posedge clk); #2;
      chk("p5.err_cleared", err_s, 2'b00);
      @(negedge clk); start_s = 1'b0;
      repeat (60) @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_channel_sched.md
# dot_channel_sched

Sequencer for one `dot_channel_25` instance. It walks the weight-bank select `cs` from 0 to NUM_CS-1. For each bank it raises `load` with a clean rising edge, waits for the channel's `valid`, captures the `data_len`-bit dot product, and streams it out through a valid/ready port with the bank index. It sits between the layer controller, which issues `start`, and the dot_channel datapath, whose `d` input it does not touch.

## Interface
Parameters:
- NUM_CS, 12, number of weight banks per pass (1..16).
- GAP, 0, extra idle cycles with `load`=0 between banks (0..15).
- TIMEOUT, 63, max LOAD cycles without `dc_valid` before error (used only with DOT_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to begin a pass; ignored while `busy`.
- abort  in  1  synchronous cancel; highest priority after reset.
- dc_load  out  1  drives dot_channel `load`.
- dc_cs  out  4  drives dot_channel `cs`.
- dc_valid  in  1  dot_channel `valid`.
- dc_q  in  `data_len`  dot_channel `q`.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  `data_len`  captured dot product.
- out_idx  out  4  bank index of `out_data`.
- busy  out  1  high from the cycle after an accepted `start` until return to IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- err  out  1  sticky timeout flag; cleared by accepted `start` or `rst`.

## Operation
- Reset values: all outputs 0; state IDLE; `dc_cs`=0.
- Outputs are registered. The FSM has states IDLE, LOAD, OUT, GAP.
- IDLE: `dc_load`=0. On `start`: `dc_cs`←0, `err`←0, go to LOAD.
- LOAD: `dc_load`=1.
  - `dc_valid`=1 → `out_data`←`dc_q`, `out_idx`←`dc_cs`, `out_valid`←1, `dc_load`←0, go to OUT.
- OUT: `dc_load`=0, and `out_valid` stays high with `out_data`/`out_idx` stable until `out_ready`.
  - `out_ready` with `dc_cs`=NUM_CS-1 → `out_valid`←0, `done`←1, go to IDLE.
  - `out_ready` otherwise → `out_valid`←0, `dc_cs`←`dc_cs`+1, then go to GAP if GAP>0, else LOAD.
- GAP: `dc_load`=0 for exactly GAP cycles, then LOAD.
- `dc_load` is low for at least one cycle between banks, so dot_channel re-initialises on every bank.
- `abort` in any state: next cycle is IDLE, with `dc_load`=0, `out_valid`=0 and the pending result dropped. No `done`; `err` unchanged.
- `start` together with `abort`: `abort` wins, and `start` is ignored.
- `start` while busy: ignored, with no effect on `dc_cs` or `err`.
- `dc_valid` outside LOAD: ignored.
- `rst` mid-pass: immediate return to reset values, with no `done`.
- `dc_cs` never exceeds NUM_CS-1. There is no wrap; the pass ends at the last bank.

## Timing
- `start` sampled at edge 0 → `busy`=1, `dc_load`=1, `dc_cs`=0 after edge 0.
- `dc_valid` sampled high at edge k → `out_valid`=1 and `dc_load`=0 after edge k (1-cycle capture latency).
- `out_ready` sampled high at edge m:
  - `out_valid`=0 after edge m.
  - With GAP=0: `dc_load`=1 with the next `dc_cs` after edge m.
  - Otherwise `dc_load`=1 after edge m+GAP.
- `done` is high for exactly the one cycle after the final accepting edge. `busy` falls together with `done`.
- Zero-backpressure throughput per bank: dot_channel latency + 1 (OUT) + GAP cycles.

## Configuration
- DOT_SCHED_TIMEOUT_EN defined:
  - A counter, reset on LOAD entry, increments each LOAD cycle without `dc_valid`.
  - When it reaches TIMEOUT: `err`←1, `dc_load`←0, go to IDLE, no `done`.
- Not defined: LOAD waits indefinitely, `err` is tied 0, and no counter logic is built.

## Test plan
- NUM_CS=3, GAP=0, `out_ready` tied 1, model `dc_valid` 12 cycles after `load` rises with `dc_q`=cs+5 → results (0,5),(1,6),(2,7), one `done` pulse, `dc_load` low exactly 1 cycle between banks.
- GAP=2, hold `out_ready` low 4 cycles on bank 1 → `out_data`/`out_idx` stable for those cycles; `dc_load` rises 2 cycles after acceptance.
- Pulse `start` during bank 1 → ignored, and sequence continues to NUM_CS-1 unchanged.
- `abort` asserted in OUT with `start` in the same cycle → IDLE next cycle, `out_valid`=0, `busy`=0, no `done`.
- With DOT_SCHED_TIMEOUT_EN and TIMEOUT=8, never assert `dc_valid` → `err`=1 and `dc_load`=0 after 8 LOAD cycles; the next `start` clears `err`.
- Assert `rst` asynchronously mid-LOAD → all outputs 0 immediately, and the next `start` begins at `dc_cs`=0.
